axi_arbiter_r: RTL and testbench
================================

// Module: axi_arbiter_r
// PURPOSE
//   Read-path arbiter for the 4-master AXI interconnect. Produces the one-hot
//   m0..m3_rgrnt selects that drive the downstream read-channel master mux.
//   Round-robin among ARVALID requesters. The grant is held from the AR handshake
//   until the last R beat completes. One read burst is outstanding per slave port.
// PARAMETERS
//   ID_WIDTH     8   width of ARID; carried only for the optional QoS compare
//   CNT_WIDTH    9   beat counter width; must be >= 9 to count ARLEN+1 = 256
// PORTS
//   ACLK          in   1  clock
//   ARESETn       in   1  reset; asynchronous assert, active-low
//   m0..m3_ARVALID in  1  per-master read-address request
//   m0..m3_ARLEN  in   8  per-master burst length; captured for the winner
//   m_ARREADY     in   1  slave-side ARREADY
//   m_RVALID      in   1  slave-side RVALID
//   m_RLAST       in   1  slave-side RLAST
//   s_RREADY      in   1  muxed RREADY of the granted master
//   m0..m3_rgrnt  out  1  registered one-hot grant; all zero when idle
//   rd_busy       out  1  high in ADDR or DATA
//   r_len_err     out  1  one-cycle pulse: RLAST beat count != ARLEN+1
// BEHAVIOUR
//   Reset: all rgrnt=0, rd_busy=0, r_len_err=0, state=IDLE, rr_ptr=0,
//     beat_cnt=0, len_q=0.
//   FSM IDLE -> ADDR -> DATA -> IDLE.
//   - IDLE: if any ARVALID, pick the winner by searching upward from rr_ptr,
//     wrapping 3->0. Register the one-hot grant and capture len_q = winner ARLEN.
//     Go to ADDR. Grant is visible 1 cycle after the request is first seen.
//   - ADDR: hold grant. On granted ARVALID && m_ARREADY, go to DATA and clear
//     beat_cnt. If the granted ARVALID drops before the handshake (protocol
//     violation), keep the grant and stay in ADDR. R-channel activity here is
//     ignored.
//   - DATA: each m_RVALID && s_RREADY increments beat_cnt.
//     On a beat with m_RLAST=1:
//       * r_len_err pulses next cycle if beat_cnt+1 != len_q+1.
//       * All grants clear next cycle, and rr_ptr = winner+1 mod 4.
//       * Go to IDLE.
//     A beat with m_RVALID && !s_RREADY is not counted.
//   - No back-to-back grant: there is always >= 1 IDLE cycle with all grants 0
//     between bursts. This guarantees the mux never switches mid-beat.
//   - Simultaneous requests: only the round-robin winner is granted; losers wait
//     with ARVALID held.
//   - Overflow: beat_cnt saturates at all-ones. ARLEN=255 gives 256 beats, which
//     is legal at CNT_WIDTH=9.
//   - Reset mid-burst: everything returns to reset values immediately. Masters
//     re-request.
//   - Invariant: $onehot0({m0..m3_rgrnt}) holds in every cycle.
// CONFIGURATION
//   AXI_ARB_QOS_EN
//   - Defined: adds inputs m0..m3_ARQOS[3:0]. In IDLE the winner is the
//     requester with the highest ARQOS. Ties are broken round-robin from rr_ptr.
//   - Undefined: the ports are absent and arbitration is pure round-robin.
//   - No other behaviour changes.
// STRUCTURE
//   Shared package axi_ic_pkg:
//   - NUM_MASTERS=4
//   - state encoding localparams ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2
//   - the one-hot grant type/width constant, also reused by the write arbiter.
//   Sub-module rr_pick4: combinational 4-way round-robin picker.
//   - Inputs: req[3:0], ptr[1:0] and optional qos.
//   - Outputs: one-hot gnt[3:0] and idx[1:0].
//   Everything else (FSM, counters, registers) lives in this module.
// TESTING
//   1. m2 ARVALID alone, ARLEN=3, slave 4 beats with RLAST on the 4th:
//      m2_rgrnt=1 from cycle+1 through the RLAST beat, then 0; r_len_err=0; rr_ptr=3.
//   2. m0..m3 request together, rr_ptr=0, 1-beat bursts:
//      grant order m0,m1,m2,m3, with >=1 all-zero cycle between grants.
//   3. ARLEN=1 but RLAST arrives on beat 3: exactly one r_len_err pulse, then IDLE.
//   4. s_RREADY low for 5 cycles with m_RVALID high: beat_cnt is frozen and the
//      grant is held.
//   5. Assert ARESETn=0 mid-DATA: grants=0 and rd_busy=0 in the same cycle
//      (async). After release, a fresh request from m0 wins (rr_ptr=0).
//   6. AXI_ARB_QOS_EN with m1 QOS=2, m3 QOS=9, and ptr=0: m3 granted first.
//      With QOS equal, m1 is granted.
//   Assertions throughout: onehot0 on grants; a grant never changes while in
//   ADDR/DATA; a 256-beat burst (ARLEN=255) gives no error.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 4-master AXI interconnect arbiters.
// Provides the FSM state encoding, master count and one-hot grant type.
package axi_ic_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int GRANT_W     = NUM_MASTERS;

    typedef logic [GRANT_W-1:0] grant_t;
    typedef logic [1:0]         state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    // Round-robin pointer advance: the slot after the last winner, wrapping 3->0.
    function automatic logic [1:0] ptr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker, searching upward from ptr.
// With AXI_ARB_QOS_EN defined, only the highest-QoS requesters are candidates.
module rr_pick4
    import axi_ic_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             ptr,
`ifdef AXI_ARB_QOS_EN
    input  logic [15:0]            qos,
`endif
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [1:0]             idx
);

    logic [NUM_MASTERS-1:0] cand;
    logic [1:0]             slot;
    logic                   found;

`ifdef AXI_ARB_QOS_EN
    logic [3:0] max_qos;

    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i] && (qos[4*i +: 4] > max_qos)) max_qos = qos[4*i +: 4];
        end
        cand = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand[i] = req[i] && (qos[4*i +: 4] == max_qos);
        end
    end
`else
    assign cand = req;
`endif

    // NOTE: every output gets a default before the search loop so no path leaves it unassigned (no latch).
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            slot = ptr + i[1:0];
            if (!found && cand[slot]) begin
                gnt[slot] = 1'b1;
                idx       = slot;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_arbiter_r.sv
// Read-path round-robin arbiter: grant held from AR handshake to the last R beat.
// Optional QoS-priority arbitration is enabled by defining AXI_ARB_QOS_EN.
module axi_arbiter_r
    import axi_ic_pkg::*;
#(
    parameter int ID_WIDTH  = 8,
    parameter int CNT_WIDTH = 9
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       m0_ARVALID,
    input  logic       m1_ARVALID,
    input  logic       m2_ARVALID,
    input  logic       m3_ARVALID,
    input  logic [7:0] m0_ARLEN,
    input  logic [7:0] m1_ARLEN,
    input  logic [7:0] m2_ARLEN,
    input  logic [7:0] m3_ARLEN,
`ifdef AXI_ARB_QOS_EN
    input  logic [3:0] m0_ARQOS,
    input  logic [3:0] m1_ARQOS,
    input  logic [3:0] m2_ARQOS,
    input  logic [3:0] m3_ARQOS,
`endif
    input  logic       m_ARREADY,
    input  logic       m_RVALID,
    input  logic       m_RLAST,
    input  logic       s_RREADY,
    output logic       m0_rgrnt,
    output logic       m1_rgrnt,
    output logic       m2_rgrnt,
    output logic       m3_rgrnt,
    output logic       rd_busy,
    output logic       r_len_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH:0]   EXT_ONE = 1;

    state_t                 state_q, state_d;
    grant_t                 gnt_q;
    logic [1:0]             win_q;
    logic [1:0]             rr_ptr;
    logic [7:0]             len_q;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic                   len_err_q;

    logic [NUM_MASTERS-1:0] arvalid;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [1:0]             pick_idx;
    logic [7:0]             len_sel;
    logic                   any_req;
    logic                   ar_hs;
    logic                   r_beat;
    logic [CNT_WIDTH:0]     beats_seen;
    logic [CNT_WIDTH:0]     beats_exp;

    assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign any_req = |arvalid;
    assign ar_hs   = (|(gnt_q & arvalid)) && m_ARREADY;
    assign r_beat  = m_RVALID && s_RREADY;

    // Compared one bit wider so a saturated counter cannot alias a legal length.
    assign beats_seen = {1'b0, beat_cnt} + EXT_ONE;
    assign beats_exp  = {{(CNT_WIDTH-7){1'b0}}, len_q} + EXT_ONE;

    rr_pick4 u_pick (
        .req (arvalid),
        .ptr (rr_ptr),
`ifdef AXI_ARB_QOS_EN
        .qos ({m3_ARQOS, m2_ARQOS, m1_ARQOS, m0_ARQOS}),
`endif
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        case (pick_idx)
            2'd0:    len_sel = m0_ARLEN;
            2'd1:    len_sel = m1_ARLEN;
            2'd2:    len_sel = m2_ARLEN;
            default: len_sel = m3_ARLEN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)           state_d = ST_ADDR;
            ST_ADDR: if (ar_hs)             state_d = ST_DATA;
            ST_DATA: if (r_beat && m_RLAST) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_busy   = (state_q == ST_ADDR) || (state_q == ST_DATA);
        r_len_err = len_err_q;
        {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt} = gnt_q;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            gnt_q     <= '0;
            win_q     <= '0;
            rr_ptr    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q <= pick_gnt;
                        win_q <= pick_idx;
                        len_q <= len_sel;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) beat_cnt <= '0;
                end
                ST_DATA: begin
                    if (r_beat) begin
                        if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_ONE;
                        // Grants drop with the last beat, forcing an all-zero IDLE cycle.
                        if (m_RLAST) begin
                            gnt_q     <= '0;
                            rr_ptr    <= ptr_next(win_q);
                            len_err_q <= (beats_seen != beats_exp);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arbiter_r.sv
// Directed self-checking bench for axi_arbiter_r (QoS case under AXI_ARB_QOS_EN).
`timescale 1ns/1ps
module tb_axi_arbiter_r;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] arvalid;
    logic [7:0] arlen [4];
    logic [3:0] qos [4];
    logic       m_ARREADY, m_RVALID, m_RLAST, s_RREADY;
    logic [3:0] gnt;
    logic       rd_busy, r_len_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_arbiter_r dut (
        .ACLK       (clk),
        .ARESETn    (rst_n),
        .m0_ARVALID (arvalid[0]),
        .m1_ARVALID (arvalid[1]),
        .m2_ARVALID (arvalid[2]),
        .m3_ARVALID (arvalid[3]),
        .m0_ARLEN   (arlen[0]),
        .m1_ARLEN   (arlen[1]),
        .m2_ARLEN   (arlen[2]),
        .m3_ARLEN   (arlen[3]),
`ifdef AXI_ARB_QOS_EN
        .m0_ARQOS   (qos[0]),
        .m1_ARQOS   (qos[1]),
        .m2_ARQOS   (qos[2]),
        .m3_ARQOS   (qos[3]),
`endif
        .m_ARREADY  (m_ARREADY),
        .m_RVALID   (m_RVALID),
        .m_RLAST    (m_RLAST),
        .s_RREADY   (s_RREADY),
        .m0_rgrnt   (gnt[0]),
        .m1_rgrnt   (gnt[1]),
        .m2_rgrnt   (gnt[2]),
        .m3_rgrnt   (gnt[3]),
        .rd_busy    (rd_busy),
        .r_len_err  (r_len_err)
    );

    // Grants are one-hot-or-zero always, and frozen while busy.
    logic [3:0] prev_gnt;
    logic       prev_busy;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gnt  = '0;
            prev_busy = 1'b0;
        end else begin
            n_checks++;
            if (!$onehot0(gnt)) $display("FAIL mon_onehot0: grants=%b are not onehot0", gnt);
            else n_pass++;
            if (prev_busy && rd_busy) begin
                n_checks++;
                if (gnt !== prev_gnt) $display("FAIL mon_grant_hold: grants=%b changed from %b while busy", gnt, prev_gnt);
                else n_pass++;
            end
            prev_gnt  = gnt;
            prev_busy = rd_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        arvalid   = '0;
        m_ARREADY = 1'b0;
        m_RVALID  = 1'b0;
        m_RLAST   = 1'b0;
        s_RREADY  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arlen[i] = 8'd0;
            qos[i]   = 4'd0;
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic addr_phase(input int m);
        m_ARREADY = 1'b1;
        tick();
        m_ARREADY  = 1'b0;
        arvalid[m] = 1'b0;
    endtask

    task automatic data_beats(input int n);
        for (int b = 0; b < n; b++) begin
            m_RVALID = 1'b1;
            s_RREADY = 1'b1;
            m_RLAST  = (b == n - 1);
            tick();
        end
        m_RVALID = 1'b0;
        m_RLAST  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({gnt, rd_busy, r_len_err} !== 6'b0) $display("FAIL reset_outputs: got %b want 000000", {gnt, rd_busy, r_len_err});
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({gnt, rd_busy} !== 5'b0) $display("FAIL reset_idle: got %b want 00000", {gnt, rd_busy});
        else n_pass++;
    endtask

    task automatic test_single_burst();
        arvalid[2] = 1'b1;
        arlen[2]   = 8'd3;
        tick();
        n_checks++;
        if (gnt !== 4'b0100 || rd_busy !== 1'b1) $display("FAIL t1_grant: got %b busy %b want 0100 busy 1", gnt, rd_busy);
        else n_pass++;
        addr_phase(2);
        for (int b = 0; b < 4; b++) begin
            m_RVALID = 1'b1;
            s_RREADY = 1'b1;
            m_RLAST  = (b == 3);
            n_checks++;
            if (gnt !== 4'b0100) $display("FAIL t1_hold_beat%0d: got %b want 0100", b, gnt);
            else n_pass++;
            tick();
        end
        m_RVALID = 1'b0;
        m_RLAST  = 1'b0;
        n_checks++;
        if ({gnt, rd_busy, r_len_err} !== 6'b0) $display("FAIL t1_end: got %b want 000000", {gnt, rd_busy, r_len_err});
        else n_pass++;
        // rr_ptr should now be 3: m3 beats m0.
        arvalid[0] = 1'b1;
        arvalid[3] = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 4'b1000) $display("FAIL t1_rr_ptr3: got %b want 1000", gnt);
        else n_pass++;
        addr_phase(3);
        data_beats(1);
        tick();
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL t1_wrap_m0: got %b want 0001", gnt);
        else n_pass++;
        addr_phase(0);
        data_beats(1);
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        apply_reset();
        arvalid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            want = 4'b0001 << k;
            tick();
            n_checks++;
            if (gnt !== want) $display("FAIL t2_order%0d: got %b want %b", k, gnt, want);
            else n_pass++;
            addr_phase(k);
            data_beats(1);
            n_checks++;
            if (gnt !== 4'b0000) $display("FAIL t2_gap%0d: got %b want 0000", k, gnt);
            else n_pass++;
        end
    endtask

    task automatic test_len_err();
        arvalid[1] = 1'b1;
        arlen[1]   = 8'd1;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) $display("FAIL t3_grant: got %b want 0010", gnt);
        else n_pass++;
        addr_phase(1);
        data_beats(3);
        n_checks++;
        if ({r_len_err, rd_busy, gnt} !== 6'b100000) $display("FAIL t3_long_pulse: got %b want 100000", {r_len_err, rd_busy, gnt});
        else n_pass++;
        tick();
        n_checks++;
        if ({r_len_err, rd_busy} !== 2'b00) $display("FAIL t3_pulse_once: got %b want 00", {r_len_err, rd_busy});
        else n_pass++;
        arvalid[1] = 1'b1;
        arlen[1]   = 8'd3;
        tick();
        addr_phase(1);
        data_beats(2);
        n_checks++;
        if (r_len_err !== 1'b1) $display("FAIL t3_short_err: got %b want 1", r_len_err);
        else n_pass++;
    endtask

    task automatic test_stall();
        arvalid[0] = 1'b1;
        arlen[0]   = 8'd1;
        tick();
        addr_phase(0);
        m_RVALID = 1'b1;
        s_RREADY = 1'b0;
        m_RLAST  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (gnt !== 4'b0001 || rd_busy !== 1'b1) $display("FAIL t4_stall%0d: got %b busy %b want 0001 busy 1", c, gnt, rd_busy);
            else n_pass++;
        end
        m_RLAST = 1'b0;
        data_beats(2);
        n_checks++;
        if ({gnt, rd_busy, r_len_err} !== 6'b0) $display("FAIL t4_after_stall: got %b want 000000", {gnt, rd_busy, r_len_err});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        arvalid[1] = 1'b1;
        arlen[1]   = 8'd3;
        tick();
        addr_phase(1);
        m_RVALID = 1'b1;
        s_RREADY = 1'b1;
        tick();
        m_RVALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, rd_busy} !== 5'b0) $display("FAIL t5_async: got %b want 00000", {gnt, rd_busy});
        else n_pass++;
        tick();
        rst_n   = 1'b1;
        arvalid = 4'b0011;
        arlen[0] = 8'd0;
        tick();
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL t5_ptr_reset: got %b want 0001", gnt);
        else n_pass++;
        addr_phase(0);
        data_beats(1);
        tick();
        addr_phase(1);
        data_beats(4);
        n_checks++;
        if (r_len_err !== 1'b0) $display("FAIL t5_m1_len: got %b want 0", r_len_err);
        else n_pass++;
    endtask

    task automatic test_max_burst();
        arvalid[2] = 1'b1;
        arlen[2]   = 8'd255;
        tick();
        n_checks++;
        if (gnt !== 4'b0100) $display("FAIL t256_grant: got %b want 0100", gnt);
        else n_pass++;
        addr_phase(2);
        data_beats(256);
        n_checks++;
        if ({gnt, rd_busy, r_len_err} !== 6'b0) $display("FAIL t256_end: got %b want 000000", {gnt, rd_busy, r_len_err});
        else n_pass++;
    endtask

`ifdef AXI_ARB_QOS_EN
    task automatic test_qos();
        apply_reset();
        qos[1]  = 4'd2;
        qos[3]  = 4'd9;
        arvalid = 4'b1010;
        tick();
        n_checks++;
        if (gnt !== 4'b1000) $display("FAIL t6_qos_high: got %b want 1000", gnt);
        else n_pass++;
        addr_phase(3);
        data_beats(1);
        arvalid = '0;
        apply_reset();
        qos[1]  = 4'd5;
        qos[3]  = 4'd5;
        arvalid = 4'b1010;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) $display("FAIL t6_qos_tie: got %b want 0010", gnt);
        else n_pass++;
        addr_phase(1);
        data_beats(1);
        arvalid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_len_err();
        test_stall();
        test_async_reset();
        test_max_burst();
`ifdef AXI_ARB_QOS_EN
        test_qos();
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
